// File: rtl/mem_pkg.sv
// Shared widths and the stage-s1 request record for the execute-stage data memory.
package mem_pkg;
    localparam int MEM_WORD_W = 16;
    localparam int ADDR_W     = 16;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [MEM_WORD_W-1:0] wdata;
        logic                  err;
    } s1_req_t;
endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Execute-stage data memory responder: fr-stage request in, x2-aligned result out two cycles later.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [MEM_WORD_W-1:0] req_wdata,
    input  logic                  flush,
    output logic [MEM_WORD_W-1:0] x2_mem,
    output logic                  x2_valid,
    output logic                  x2_err,
    output logic [15:0]           ld_count,
    output logic [15:0]           st_count
);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    s1_req_t               s1;
    logic [ADDR_W-1:0]     req_word;
    logic                  req_err;
    logic [MEM_WORD_W-1:0] mem [DEPTH];
    logic [MEM_WORD_W-1:0] rdata;
    logic                  s1_live;
    logic                  wr_en;
    logic                  ld_en;

    assign req_word = {1'b0, req_addr[ADDR_W-1:1]};
    assign req_err  = req_addr[0] | (req_word >= DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1 <= '{valid: req_valid, we: req_we, addr: req_addr,
                    wdata: req_wdata, err: req_err};
        end
    end

    assign rdata = mem[s1.addr[AW:1]];

    // A request only takes effect if it survives flush, is well formed and reset is not winning.
    assign s1_live = s1.valid & ~flush & ~s1.err & ~rst;
    assign wr_en   = s1_live & s1.we;
    assign ld_en   = s1_live & ~s1.we;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[s1.addr[AW:1]] <= s1.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x2_mem   <= '0;
            x2_valid <= 1'b0;
            x2_err   <= 1'b0;
        end else begin
            x2_valid <= s1.valid & ~flush;
            x2_err   <= s1.valid & s1.err & ~flush;
            if (s1.valid) begin
                x2_mem <= s1.err ? '0 : (s1.we ? s1.wdata : rdata);
            end
        end
    end

    sat_counter16 u_ld_count (
        .clk   (clk),
        .rst   (rst),
        .en    (ld_en),
        .count (ld_count)
    );

    sat_counter16 u_st_count (
        .clk   (clk),
        .rst   (rst),
        .en    (wr_en),
        .count (st_count)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed checks of data_mem_responder against a word-array reference model.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        flush;
    logic [15:0] x2_mem;
    logic        x2_valid;
    logic        x2_err;
    logic [15:0] ld_count;
    logic [15:0] st_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] model_mem [DEPTH];
    bit          p_v;
    bit          p_we;
    logic [15:0] p_addr;
    logic [15:0] p_wd;
    logic [15:0] exp_mem;
    bit          exp_valid;
    bit          exp_err;
    bit          mem_known;
    logic [15:0] exp_ld;
    logic [15:0] exp_st;

    data_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .flush     (flush),
        .x2_mem    (x2_mem),
        .x2_valid  (x2_valid),
        .x2_err    (x2_err),
        .ld_count  (ld_count),
        .st_count  (st_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: run still going (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs();
        chk("x2_valid", 16'(x2_valid), 16'(exp_valid));
        chk("x2_err", 16'(x2_err), 16'(exp_err));
        if (mem_known) chk("x2_mem", x2_mem, exp_mem);
        chk("ld_count", ld_count, exp_ld);
        chk("st_count", st_count, exp_st);
    endtask

    // Retire the request issued one step earlier, as seen after the edge that ends its s1 cycle.
    task automatic retire(input bit fl);
        bit bad_addr;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (p_v && fl) begin
            mem_known = 1'b0;
        end else if (p_v) begin
            bad_addr  = p_addr[0] || (int'(p_addr) / 2 >= DEPTH);
            exp_valid = 1'b1;
            exp_err   = bad_addr;
            mem_known = 1'b1;
            if (bad_addr) begin
                exp_mem = 16'h0000;
            end else if (p_we) begin
                model_mem[p_addr / 2] = p_wd;
                exp_mem = p_wd;
                if (exp_st != 16'hFFFF) exp_st = exp_st + 16'd1;
            end else begin
                exp_mem = model_mem[p_addr / 2];
                if (exp_ld != 16'hFFFF) exp_ld = exp_ld + 16'd1;
            end
        end
    endtask

    // One cycle: issue a request; fl squashes the request issued on the previous step.
    task automatic step(input bit v, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, input bit fl);
        rst       = 1'b0;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        flush     = fl;
        @(posedge clk);
        retire(fl);
        p_v    = v;
        p_we   = we;
        p_addr = a;
        p_wd   = wd;
        #1;
        check_outputs();
    endtask

    task automatic reset_cycle();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0002;
        req_wdata = 16'hDEAD;
        flush     = 1'b0;
        @(posedge clk);
        p_v       = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_mem   = 16'h0000;
        mem_known = 1'b1;
        exp_ld    = 16'h0000;
        exp_st    = 16'h0000;
        #1;
        check_outputs();
        rst       = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 16'($urandom);
            1:       return (16'($urandom_range(0, DEPTH - 1)) << 1) | 16'h0001;
            2:       return 16'(2 * DEPTH) + (16'($urandom_range(0, 64)) << 1);
            default: return 16'($urandom_range(0, DEPTH - 1)) << 1;
        endcase
    endfunction

    initial begin
        logic [15:0] saved_st;
        logic [15:0] saved_w0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; flush = 1'b0;
        p_v = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
        repeat (2) @(posedge clk);
        reset_cycle();

        // fill every word so later loads have a defined expected value
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 16'(2 * i), 16'($urandom), 1'b0);
        idle();
        reset_cycle();

        // store then load of the same word, back to back
        step(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("beef_echo", x2_mem, 16'hBEEF);
        idle();
        chk("beef_load", x2_mem, 16'hBEEF);
        chk("beef_ld1", ld_count, 16'd1);
        chk("beef_st1", st_count, 16'd1);

        // misaligned / out-of-range accesses
        step(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0);
        chk("mis_err", 16'(x2_err), 16'h0001);
        chk("mis_zero", x2_mem, 16'h0000);
        saved_w0 = model_mem[0];
        step(1'b1, 1'b1, 16'h0200, 16'h5A5A, 1'b0);
        chk("oor_err", 16'(x2_err), 16'h0001);
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        idle();
        chk("word0_kept", x2_mem, saved_w0);

        // flushed store must not commit
        saved_st = exp_st;
        step(1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("flush_valid", 16'(x2_valid), 16'h0000);
        chk("flush_st", st_count, saved_st);
        step(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
        idle();

        // alternating stream, one per cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2) == 0, 16'(2 * i), 16'($urandom), 1'b0);
        end
        idle();
        idle();

        // reset lands while a store sits in s1
        step(1'b1, 1'b1, 16'h0006, 16'hCAFE, 1'b0);
        reset_cycle();
        step(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0);
        idle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_cycle();
            end else begin
                step($urandom_range(0, 9) < 8, 1'($urandom), rand_addr(),
                     16'($urandom), $urandom_range(0, 9) == 0);
            end
        end
        idle();

        // drive ld_count into saturation and past it
        reset_cycle();
        for (int n = 0; n < 65537; n++) begin
            step(1'b1, 1'b0, 16'($urandom_range(0, DEPTH - 1)) << 1, 16'h0000, 1'b0);
        end
        idle();
        chk("ld_sat", ld_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
